// File: rtl/lb_row_sched.sv
// -----------------------------------------------------------------------------
// lb_row_sched
//   Row scheduler for a 3-line-buffer 3x3 convolution engine. Incoming pixels
//   are written one row per buffer into LB0/LB1/LB2 in rotation. Once three
//   rows are resident the conv engine is told to run (conv_data_valid) and is
//   given the rotation index conv_k of the top row. The scheduler then waits for
//   the engine's end-of-row ready before overwriting the oldest buffer.
//
// Parameters
//   IMG_W  - pixels per row
//   IMG_H  - rows per frame (>= 3)
//   ADDR_W - line-buffer address width, 2**ADDR_W >= IMG_W
//
// Ports
//   clk             in   clock
//   rst             in   asynchronous reset, active low
//   start           in   frame start pulse, only honoured in IDLE
//   pix_valid       in   source pixel valid
//   pix_data        in   source pixel [7:0]
//   pix_ready       out  pixel accepted this cycle when pix_valid is high
//   lb_wr_en        out  one-hot line-buffer write enable [2:0]
//   lb_wr_addr      out  write address within the row [ADDR_W-1:0]
//   lb_wr_data      out  registered pixel [7:0]
//   conv_data_valid out  3-row window resident, conv engine may run
//   conv_k          out  rotation index of the top-row buffer [1:0]
//   conv_ready      in   conv engine end-of-row indication
//   busy            out  scheduler not idle
//   frame_done      out  one-cycle pulse at end of frame
//   stall_cnt       out  stall counter [15:0]
//
// Build option
//   LB_SCHED_PERF_EN - when defined, stall_cnt counts busy cycles where the
//                      source offers a pixel that is not accepted (saturating,
//                      cleared on an accepted start, held in IDLE). When not
//                      defined, stall_cnt is constant zero.
// -----------------------------------------------------------------------------
module lb_row_sched #(
   parameter int IMG_W  = 100,
   parameter int IMG_H  = 100,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic [2:0]        lb_wr_en,
   output logic [ADDR_W-1:0] lb_wr_addr,
   output logic [7:0]        lb_wr_data,
   output logic              conv_data_valid,
   output logic [1:0]        conv_k,
   input  logic              conv_ready,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       stall_cnt
);

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
   localparam logic [15:0]       ROW_LAST = 16'(IMG_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CONV,
      S_LOAD,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [ADDR_W-1:0] r_col;
   logic [15:0]       r_row;
   logic [1:0]        r_buf_sel;
   logic [1:0]        r_conv_k;
   logic              r_dv;
   logic [2:0]        r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;

   logic              w_pix_ready;
   logic              w_busy;
   logic              w_start_acc;
   logic              w_xfer;
   logic              w_row_done;
   logic              w_conv_rdy;
   logic              w_last_row;
   logic [2:0]        w_buf_oh;

   assign w_start_acc = (r_state == S_IDLE) & start;
   assign w_xfer      = pix_valid & w_pix_ready;
   assign w_row_done  = w_xfer & (r_col == COL_LAST);
   assign w_conv_rdy  = (r_state == S_CONV) & conv_ready;
   assign w_last_row  = (r_row == ROW_LAST);
   assign w_buf_oh    = 3'b001 << r_buf_sel;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_FILL;
         end
         S_FILL: begin
            // third row (into LB2) completes the initial window
            if (w_row_done && (r_buf_sel == 2'd2)) w_next = S_CONV;
         end
         S_CONV: begin
            if (conv_ready) w_next = w_last_row ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            if (w_row_done) w_next = S_CONV;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: state-decoded outputs
   // --------------------------------------------------------------------------
   always_comb begin
      w_pix_ready = 1'b0;
      w_busy      = 1'b1;
      frame_done  = 1'b0;
      case (r_state)
         S_IDLE: w_busy      = 1'b0;
         S_FILL: w_pix_ready = 1'b1;
         S_LOAD: w_pix_ready = 1'b1;
         S_DONE: frame_done  = 1'b1;
         default: ;
      endcase
   end

   assign pix_ready = w_pix_ready;
   assign busy      = w_busy;

   // --------------------------------------------------------------------------
   // Column / row counters
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_start_acc) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_xfer) begin
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + 16'd1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Buffer rotation: buf_sel is the buffer being written, conv_k the top row.
   // When a CONV phase ends the top row is the oldest, so it becomes the next
   // buffer to overwrite and the window rotates by one.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf_sel <= '0;
         r_conv_k  <= '0;
      end else begin
         if (w_start_acc) begin
            r_buf_sel <= '0;
            r_conv_k  <= '0;
         end else if ((r_state == S_FILL) && w_row_done) begin
            r_buf_sel <= (r_buf_sel == 2'd2) ? 2'd0 : r_buf_sel + 2'd1;
         end else if (w_conv_rdy && !w_last_row) begin
            r_buf_sel <= r_conv_k;
            r_conv_k  <= (r_conv_k == 2'd2) ? 2'd0 : r_conv_k + 2'd1;
         end else if (r_state == S_DONE) begin
            r_conv_k  <= '0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Window-valid flag. The combinational gate with conv_ready keeps the
   // engine from re-launching in the same cycle it reports end-of-row.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dv <= 1'b0;
      end else if (w_conv_rdy) begin
         r_dv <= 1'b0;
      end else if ((w_next == S_CONV) && (r_state != S_CONV)) begin
         r_dv <= 1'b1;
      end
   end

   assign conv_data_valid = r_dv & ~conv_ready;
   assign conv_k          = r_conv_k;

   // --------------------------------------------------------------------------
   // Line-buffer write port, one cycle behind the pixel handshake
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_en   <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_xfer ? w_buf_oh : 3'b000;
         if (w_xfer) begin
            r_wr_addr <= r_col;
            r_wr_data <= pix_data;
         end
      end
   end

   assign lb_wr_en   = r_wr_en;
   assign lb_wr_addr = r_wr_addr;
   assign lb_wr_data = r_wr_data;

   // --------------------------------------------------------------------------
   // Stall counter
   // --------------------------------------------------------------------------
`ifdef LB_SCHED_PERF_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (w_start_acc) begin
         r_stall <= '0;
      end else if (w_busy && pix_valid && !w_pix_ready && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign stall_cnt = r_stall;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_lb_row_sched.sv
module tb_lb_row_sched;

   localparam int W  = 100;
   localparam int H  = 5;
   localparam int AW = 7;

`ifdef LB_SCHED_PERF_EN
   localparam int EXP_STALL = 50;
`else
   localparam int EXP_STALL = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          pix_valid;
   logic [7:0]    pix_data;
   logic          pix_ready;
   logic [2:0]    lb_wr_en;
   logic [AW-1:0] lb_wr_addr;
   logic [7:0]    lb_wr_data;
   logic          conv_data_valid;
   logic [1:0]    conv_k;
   logic          conv_ready;
   logic          busy;
   logic          frame_done;
   logic [15:0]   stall_cnt;

   lb_row_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk             (clk),
      .rst             (rst_n),
      .start           (start),
      .pix_valid       (pix_valid),
      .pix_data        (pix_data),
      .pix_ready       (pix_ready),
      .lb_wr_en        (lb_wr_en),
      .lb_wr_addr      (lb_wr_addr),
      .lb_wr_data      (lb_wr_data),
      .conv_data_valid (conv_data_valid),
      .conv_k          (conv_k),
      .conv_ready      (conv_ready),
      .busy            (busy),
      .frame_done      (frame_done),
      .stall_cnt       (stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard of expected line-buffer writes ----------------
   typedef struct {
      logic [2:0]    en;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t sbq[$];
   wr_t sb_e;
   int  sb_row;
   int  done_pulses;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && lb_wr_en !== 3'b000) begin
         if (sbq.size() == 0) begin
            check("unexpected lb write", {29'd0, lb_wr_en}, 32'd0);
         end else begin
            sb_e = sbq.pop_front();
            check("lb_wr_en", {29'd0, lb_wr_en}, {29'd0, sb_e.en});
            check("lb_wr_addr", 32'(lb_wr_addr), 32'(sb_e.addr));
            check("lb_wr_data", {24'd0, lb_wr_data}, {24'd0, sb_e.data});
         end
      end
      if (frame_done === 1'b1) done_pulses++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic st, input logic pv, input logic cr, input logic [7:0] d);
      @(posedge clk);
      #1;
      start      = st;
      pix_valid  = pv;
      conv_ready = cr;
      pix_data   = d;
      @(negedge clk);
   endtask

   task automatic send_row(input int n, input logic cr_hold);
      int bad;
      logic [7:0] d;
      wr_t w;
      bad = 0;
      for (int c = 0; c < n; c++) begin
         d = 8'($urandom);
         step(1'b0, 1'b1, cr_hold, d);
         w.en   = 3'(1 << (sb_row % 3));
         w.addr = AW'(c);
         w.data = d;
         sbq.push_back(w);
         if (pix_ready !== 1'b1 || conv_data_valid !== 1'b0) bad++;
      end
      if (n == W) sb_row++;
      check("pix_ready during row", 32'(bad), 32'd0);
   endtask

   task automatic wait_conv(input int n, input logic [1:0] k, input logic pv, input logic st);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         step(st && (i == n / 2), pv, 1'b0, 8'h00);
         if (conv_data_valid !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      check("conv window flags", 32'(bad), 32'd0);
      check("conv_k in CONV", {30'd0, conv_k}, {30'd0, k});
   endtask

   task automatic pulse_ready(input logic [1:0] k);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("dv gated by conv_ready", {31'd0, conv_data_valid}, 32'd0);
      check("conv_k at ready", {30'd0, conv_k}, {30'd0, k});
   endtask

   task automatic do_start();
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("busy before start taken", {31'd0, busy}, 32'd0);
      sb_row      = 0;
      done_pulses = 0;
   endtask

   // ---------------- frame script table ----------------
   typedef enum int {OP_START, OP_ROW, OP_WAIT, OP_READY, OP_DONE} op_e;
   typedef struct {
      op_e        op;
      int         n;
      logic       pv;
      logic       st;
      logic       cr;
      logic [1:0] k;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{OP_START, 0,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[1]  = '{OP_ROW,   W,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[2]  = '{OP_ROW,   W,  1'b0, 1'b0, 1'b1, 2'd0}; // conv_ready in FILL
      tbl[3]  = '{OP_ROW,   W,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[4]  = '{OP_WAIT,  50, 1'b1, 1'b0, 1'b0, 2'd0}; // source stalls
      tbl[5]  = '{OP_WAIT,  48, 1'b0, 1'b1, 1'b0, 2'd0}; // start in CONV
      tbl[6]  = '{OP_READY, 0,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[7]  = '{OP_ROW,   W,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[8]  = '{OP_WAIT,  98, 1'b0, 1'b0, 1'b0, 2'd1};
      tbl[9]  = '{OP_READY, 0,  1'b0, 1'b0, 1'b0, 2'd1};
      tbl[10] = '{OP_ROW,   W,  1'b0, 1'b0, 1'b0, 2'd0};
      tbl[11] = '{OP_WAIT,  98, 1'b0, 1'b0, 1'b0, 2'd2};
      tbl[12] = '{OP_READY, 0,  1'b0, 1'b0, 1'b0, 2'd2};
      tbl[13] = '{OP_DONE,  0,  1'b0, 1'b0, 1'b0, 2'd0};

      rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; conv_ready = 1'b0; pix_data = 8'h00;
      sb_row = 0; done_pulses = 0;
      repeat (3) @(negedge clk);
      check("reset pix_ready", {31'd0, pix_ready}, 32'd0);
      check("reset lb_wr_en", {29'd0, lb_wr_en}, 32'd0);
      check("reset conv_dv", {31'd0, conv_data_valid}, 32'd0);
      check("reset conv_k", {30'd0, conv_k}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset frame_done", {31'd0, frame_done}, 32'd0);
      check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- full frame driven from the table ----
      for (int i = 0; i < 14; i++) begin
         case (tbl[i].op)
            OP_START: do_start();
            OP_ROW:   send_row(tbl[i].n, tbl[i].cr);
            OP_WAIT:  wait_conv(tbl[i].n, tbl[i].k, tbl[i].pv, tbl[i].st);
            OP_READY: pulse_ready(tbl[i].k);
            OP_DONE: begin
               step(1'b0, 1'b0, 1'b0, 8'h00);
               check("frame_done pulse", {31'd0, frame_done}, 32'd1);
               check("busy in DONE", {31'd0, busy}, 32'd1);
               step(1'b0, 1'b0, 1'b0, 8'h00);
               check("frame_done cleared", {31'd0, frame_done}, 32'd0);
               check("busy after frame", {31'd0, busy}, 32'd0);
               check("conv_k after frame", {30'd0, conv_k}, 32'd0);
            end
            default: ;
         endcase
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
      check("frame_done pulses", 32'(done_pulses), 32'd1);
      check("stall_cnt after stall", {16'd0, stall_cnt}, 32'(EXP_STALL));
      check("writes outstanding", 32'(sbq.size()), 32'd0);

      // ---- second frame, reset in the middle of the first LOAD ----
      do_start();
      send_row(W, 1'b0);
      check("stall_cnt cleared on start", {16'd0, stall_cnt}, 32'd0);
      send_row(W, 1'b0);
      send_row(W, 1'b0);
      wait_conv(98, 2'd0, 1'b0, 1'b0);
      pulse_ready(2'd0);
      send_row(40, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00);   // last partial-row write drains here
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst pix_ready", {31'd0, pix_ready}, 32'd0);
      check("async rst lb_wr_en", {29'd0, lb_wr_en}, 32'd0);
      check("async rst lb_wr_addr", 32'(lb_wr_addr), 32'd0);
      check("async rst lb_wr_data", {24'd0, lb_wr_data}, 32'd0);
      check("async rst conv_dv", {31'd0, conv_data_valid}, 32'd0);
      check("async rst conv_k", {30'd0, conv_k}, 32'd0);
      check("async rst busy", {31'd0, busy}, 32'd0);
      check("async rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
      check("writes before reset", 32'(sbq.size()), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // restart must begin again at LB0, address 0
      do_start();
      send_row(W, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
      check("busy after restart", {31'd0, busy}, 32'd1);
      check("writes outstanding end", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
